// File: rtl/requant_leaky_int8_pkg.sv
// Shared widths, configuration record and saturation helper for the
// int8 requantisation pipeline.
package requant_pkg;

  localparam int unsigned ACC_W       = 32;
  localparam int unsigned SCALE_W     = 16;
  localparam int unsigned SHIFT_W     = 5;
  localparam int unsigned LEAKY_NUM   = 13;
  localparam int unsigned LEAKY_SHIFT = 7;

  // Datapath widths sized so no stage can overflow.
  localparam int unsigned S1_W = ACC_W + 1;          // bias add
  localparam int unsigned S2_W = S1_W + SCALE_W + 1; // signed x zero-extended scale
  localparam int unsigned S3_W = S2_W + 1;           // rounding add headroom
  localparam int unsigned S4_W = S3_W + 4;           // x13 headroom

  localparam logic signed [S4_W-1:0] LEAKY_MUL = LEAKY_NUM;
  localparam logic signed [S4_W-1:0] SAT_HI    = 127;
  localparam logic signed [S4_W-1:0] SAT_LO    = -128;

  typedef struct packed {
    logic signed [ACC_W-1:0] bias;
    logic [SCALE_W-1:0]      scale;
    logic [SHIFT_W-1:0]      shift;
    logic                    leaky;
  } requant_cfg_t;

  // Identity transform: only saturation is applied.
  localparam requant_cfg_t CFG_RESET = '{
    bias:  '0,
    scale: SCALE_W'(1),
    shift: '0,
    leaky: 1'b0
  };

  function automatic logic signed [7:0] sat_int8(input logic signed [S4_W-1:0] y);
    if (y > SAT_HI) begin
      return 8'sh7f;
    end else if (y < SAT_LO) begin
      return 8'sh80;
    end
    return y[7:0];
  endfunction

endpackage

// File: rtl/requant_leaky_int8_pipe_ctl.sv
// Generic N-stage valid/ready controller with bubble collapsing.
// Produces the per-stage load enables for an external datapath.
module pipe_ctl #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         out_ready,
  output logic         in_ready,
  output logic [N-1:0] load,
  output logic [N-1:0] valid
);

  logic [N-1:0] valid_q, valid_d;
  logic [N-1:0] adv;
  logic         room;

  // Walk from the output back: a stage advances if anything downstream has
  // room (an empty slot or the output draining), which collapses bubbles.
  always_comb begin
    adv  = '0;
    room = out_ready;
    for (int unsigned i = 0; i < N; i++) begin
      adv[N-1-i] = valid_q[N-1-i] & room;
      room       = room | ~valid_q[N-1-i];
    end
    in_ready = rst_n & room;
    load     = {adv[N-2:0], in_valid & in_ready};
    valid_d  = load | (valid_q & ~adv);
  end

  // Stage valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/requant_leaky_int8.sv
// Accumulator requantisation: bias add, fixed-point scale, rounding shift,
// optional leaky-ReLU and int8 saturation in a 4-stage valid/ready pipe.
module requant_leaky_int8
  import requant_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [ACC_W-1:0]   cfg_bias,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_leaky,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         data_out,
  output logic               out_last
);

  localparam int unsigned NSTAGE = 4;

  logic [NSTAGE-1:0] stage_load;
  logic [NSTAGE-1:0] stage_valid;

  requant_cfg_t cfg_q, cfg_d;

  logic signed [S1_W-1:0] s1_q, s1_d;
  logic signed [S2_W-1:0] s2_q, s2_d;
  logic signed [S3_W-1:0] s3_q, s3_d;
  logic signed [7:0]      act_q, act_d;
  logic [NSTAGE-1:0]      last_q, last_d;

  logic signed [S3_W-1:0] s2_ext, rnd, s3_calc;
  logic signed [S4_W-1:0] s3_ext, y4;

  pipe_ctl #(.N(NSTAGE)) u_pipe_ctl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .load      (stage_load),
    .valid     (stage_valid)
  );

  assign busy      = |stage_valid;
  assign out_valid = stage_valid[NSTAGE-1];
  assign data_out  = act_q;
  assign out_last  = last_q[NSTAGE-1];

  // Config only changes with the pipe empty and no word offered, so every
  // in-flight word sees one consistent configuration.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_load && !busy && !in_valid) begin
      cfg_d.bias  = cfg_bias;
      cfg_d.scale = cfg_scale;
      cfg_d.shift = cfg_shift;
      cfg_d.leaky = cfg_leaky;
    end
  end

  // Round-half-up right shift; shift of zero passes through unchanged.
  always_comb begin
    s2_ext = S3_W'(s2_q);
    rnd    = '0;
    if (cfg_q.shift != '0) begin
      rnd = S3_W'(1) << (cfg_q.shift - SHIFT_W'(1));
    end
    s3_calc = (s2_ext + rnd) >>> cfg_q.shift;
  end

  // Leaky slope 13/128 with floor, applied to negative values only.
  always_comb begin
    s3_ext = S4_W'(s3_q);
    y4     = s3_ext;
    if (cfg_q.leaky && s3_q[S3_W-1]) begin
      y4 = (s3_ext * LEAKY_MUL) >>> LEAKY_SHIFT;
    end
  end

  // Stage loads: each register takes its new value only when enabled.
  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    act_d  = act_q;
    last_d = last_q;
    if (stage_load[0]) begin
      s1_d      = S1_W'($signed(acc_in)) + S1_W'($signed(cfg_q.bias));
      last_d[0] = in_last;
    end
    if (stage_load[1]) begin
      s2_d      = S2_W'(s1_q) * S2_W'($signed({1'b0, cfg_q.scale}));
      last_d[1] = last_q[0];
    end
    if (stage_load[2]) begin
      s3_d      = s3_calc;
      last_d[2] = last_q[1];
    end
    if (stage_load[3]) begin
      act_d     = sat_int8(y4);
      last_d[3] = last_q[2];
    end
  end

  // Configuration and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q  <= CFG_RESET;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      act_q  <= '0;
      last_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      act_q  <= act_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_requant_leaky_int8.sv
// Self-checking bench for requant_leaky_int8 using an expected-value queue.
module tb_requant_leaky_int8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_bias = '0;
  logic [15:0] cfg_scale = 16'd1;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_leaky = 1'b0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] acc_in = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  data_out;
  logic        out_last;

  requant_leaky_int8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .cfg_bias  (cfg_bias),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cfg_leaky (cfg_leaky),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_in    (acc_in),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference configuration mirrored by the bench.
  int          m_bias  = 0;
  int unsigned m_scale = 1;
  int unsigned m_shift = 0;
  logic        m_leaky = 1'b0;

  function automatic logic [7:0] model(input logic [31:0] a);
    longint s;
    s = longint'($signed(a)) + longint'(m_bias);
    s = s * longint'(m_scale);
    if (m_shift != 0) s = (s + (longint'(1) <<< (m_shift - 1))) >>> m_shift;
    if (m_leaky && s < 0) s = (s * 13) >>> 7;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s[7:0];
  endfunction

  // One clock cycle: drive at the falling edge, sample handshakes 1ns later.
  task automatic cycle(input logic vld, input logic [31:0] a, input logic lst,
                       input logic ordy, input logic cl,
                       output logic acc_ok, output logic dlv);
    @(negedge clk);
    cyc++;
    in_valid  = vld;
    acc_in    = a;
    in_last   = lst;
    out_ready = ordy;
    cfg_load  = cl;
    #1;
    acc_ok = vld && in_ready;
    dlv    = out_valid && ordy;
  endtask

  task automatic cfg_write(input int b, input int unsigned s, input int unsigned sh, input logic lk);
    logic a, d;
    for (int unsigned i = 0; i < 40 && busy; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, a, d);
    if (busy) begin
      tests++; fails++;
      $display("FAIL cfg_idle: busy=%0b required 0 before config load", busy);
    end
    cfg_bias  = b;
    cfg_scale = s[15:0];
    cfg_shift = sh[4:0];
    cfg_leaky = lk;
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, a, d);
    m_bias = b; m_scale = s; m_shift = sh; m_leaky = lk;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || data_out !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: ov=%0b d=%0h ol=%0b busy=%0b ir=%0b required 0 00 0 0 1",
               out_valid, data_out, out_last, busy, in_ready);
    end
  endtask

  // Single-word cases with constant expected results and 4-cycle latency.
  task automatic test_arith();
    int          t_bias [14] = '{0, 0, 0, 24, 24, 0, 0, 0, 0, 0, 0, 0, 32'h7fffffff, 32'sh80000000};
    int unsigned t_scale[14] = '{1, 1, 1, 16384, 16384, 1, 1, 1, 1, 1, 1, 1, 65535, 65535};
    int unsigned t_shift[14] = '{0, 0, 0, 14, 14, 1, 1, 1, 0, 0, 0, 0, 31, 31};
    logic        t_leaky[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int          t_acc  [14] = '{100, 300, -300, 76, -124, 3, -3, -4, -100, -5, -100000, 50,
                                 32'h7fffffff, 32'sh80000000};
    int          t_exp  [14] = '{100, 127, -128, 100, -100, 2, -1, -2, -11, -1, -128, 50, 127, -128};
    logic a, d, got;
    exp_t e;
    for (int unsigned k = 0; k < 14; k++) begin
      if (t_bias[k] != m_bias || t_scale[k] != m_scale || t_shift[k] != m_shift || t_leaky[k] != m_leaky)
        cfg_write(t_bias[k], t_scale[k], t_shift[k], t_leaky[k]);
      cycle(1'b1, t_acc[k], 1'b0, 1'b1, 1'b0, a, d);
      tests++;
      if (a !== 1'b1) begin
        fails++; $display("FAIL arith_accept[%0d]: accepted=%0b required 1", k, a);
      end
      e.d = 8'(t_exp[k]); e.l = 1'b0; e.c = cyc;
      if (a) sb.push_back(e);
      got = 1'b0;
      for (int unsigned j = 0; j < 8 && !got && sb.size() > 0; j++) begin
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, a, d);
        if (k == 0 && j == 0) begin
          tests++;
          if (busy !== 1'b1) begin
            fails++; $display("FAIL busy_after_accept: got %0b required 1", busy);
          end
        end
        if (d) begin
          e = sb.pop_front();
          got = 1'b1;
          tests++;
          if (data_out !== e.d || out_last !== e.l || cyc - e.c != 4) begin
            fails++;
            $display("FAIL arith[%0d]: data=%0d last=%0b lat=%0d required data=%0d last=%0b lat=4",
                     k, $signed(data_out), out_last, cyc - e.c, $signed(e.d), e.l);
          end
        end
      end
      if (!got) begin
        tests++; fails++;
        $display("FAIL arith_timeout[%0d]: no output, required data=%0d", k, t_exp[k]);
        sb.delete();
      end
    end
  endtask

  // Full-throughput stream against the reference model.
  task automatic test_back_to_back();
    int unsigned sent = 0, got = 0;
    logic a, d, vld;
    logic [31:0] v;
    exp_t e;
    cfg_write(-50, 300, 6, 1'b1);
    for (int unsigned i = 0; i < 80 && got < 40; i++) begin
      vld = (sent < 40);
      v = 32'(int'($urandom_range(4000)) - 2000);
      cycle(vld, v, (sent == 39), 1'b1, 1'b0, a, d);
      if (vld) begin
        tests++;
        if (!a) begin
          fails++; $display("FAIL b2b_ready[%0d]: in_ready=%0b required 1", sent, in_ready);
        end
      end
      if (a) begin
        e.d = model(v); e.l = (sent == 39); e.c = cyc;
        sb.push_back(e);
        sent++;
      end
      if (d) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_extra: data=%0h required no output", data_out);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.d || out_last !== e.l || cyc - e.c != 4) begin
            fails++;
            $display("FAIL b2b[%0d]: data=%0d last=%0b lat=%0d required data=%0d last=%0b lat=4",
                     got, $signed(data_out), out_last, cyc - e.c, $signed(e.d), e.l);
          end
        end
        got++;
      end
    end
    tests++;
    if (got != 40) begin
      fails++; $display("FAIL b2b_count: got %0d words required 40", got);
    end
  endtask

  // Ten words, downstream stalled for cycles 3..12.
  task automatic test_backpressure();
    int unsigned sent = 0, got = 0;
    logic a, d, vld, ordy, prev_stall = 1'b0, saw_full = 1'b0;
    logic [7:0] prev_d = '0;
    logic prev_l = 1'b0;
    logic [31:0] v;
    exp_t e;
    for (int unsigned i = 1; i <= 60 && got < 10; i++) begin
      vld  = (sent < 10);
      ordy = !(i >= 3 && i <= 12);
      v    = 32'(int'(sent) * 37 - 150);
      cycle(vld, v, (sent == 9), ordy, 1'b0, a, d);
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || data_out !== prev_d || out_last !== prev_l) begin
          fails++;
          $display("FAIL bp_hold: ov=%0b data=%0h last=%0b required 1 %0h %0b",
                   out_valid, data_out, out_last, prev_d, prev_l);
        end
      end
      prev_stall = out_valid && !ordy;
      prev_d = data_out;
      prev_l = out_last;
      if (vld && !in_ready && !saw_full) begin
        saw_full = 1'b1;
        tests++;
        if (sb.size() != 4) begin
          fails++; $display("FAIL bp_full: held %0d words when in_ready fell, required 4", sb.size());
        end
      end
      if (i == 13) begin
        tests++;
        if (in_ready !== 1'b1) begin
          fails++; $display("FAIL bp_release: in_ready=%0b required 1", in_ready);
        end
      end
      if (a) begin
        e.d = model(v); e.l = (sent == 9); e.c = cyc;
        sb.push_back(e);
        sent++;
      end
      if (d) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL bp_extra: data=%0h required no output", data_out);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.d || out_last !== e.l) begin
            fails++;
            $display("FAIL bp_word[%0d]: data=%0d last=%0b required data=%0d last=%0b",
                     got, $signed(data_out), out_last, $signed(e.d), e.l);
          end
        end
        got++;
      end
    end
    tests++;
    if (!saw_full || got != 10) begin
      fails++; $display("FAIL bp_summary: full_seen=%0b words=%0d required 1 and 10", saw_full, got);
    end
  endtask

  // cfg_load while busy must be ignored.
  task automatic test_cfg_guard();
    int unsigned got = 0, sent = 0;
    logic a, d;
    exp_t e;
    cfg_write(0, 2, 0, 1'b0);
    cycle(1'b1, 32'd10, 1'b0, 1'b1, 1'b0, a, d);
    if (a) begin e.d = 8'd20; e.l = 1'b0; e.c = cyc; sb.push_back(e); sent++; end
    cfg_scale = 16'd5;
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, a, d);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL guard_busy: busy=%0b required 1 during ignored load", busy);
    end
    cycle(1'b1, 32'd7, 1'b0, 1'b1, 1'b0, a, d);
    if (a) begin e.d = 8'd14; e.l = 1'b1; e.c = cyc; sb.push_back(e); sent++; end
    for (int unsigned i = 0; i < 20 && sb.size() > 0; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, a, d);
      if (d) begin
        e = sb.pop_front();
        e.l = 1'b0;
        tests++;
        if (data_out !== e.d || out_last !== e.l) begin
          fails++;
          $display("FAIL guard_word[%0d]: data=%0d last=%0b required data=%0d last=0",
                   got, $signed(data_out), out_last, $signed(e.d));
        end
        got++;
      end
    end
    tests++;
    if (got != 2 || sent != 2) begin
      fails++; $display("FAIL guard_count: sent=%0d got=%0d required 2 and 2", sent, got);
    end
  endtask

  // Reset with three words in flight: nothing stale may appear afterwards.
  task automatic test_mid_reset();
    int unsigned stale = 0, got = 0;
    logic a, d;
    exp_t e;
    cfg_write(0, 2, 0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 32'(i + 1), 1'b0, 1'b1, 1'b0, a, d);
    @(negedge clk);
    cyc++;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL mid_reset_in_ready: got %0b required 0", in_ready);
    end
    @(negedge clk);
    cyc++;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_state: ov=%0b busy=%0b data=%0h required 0 0 00", out_valid, busy, data_out);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_release: in_ready=%0b required 1", in_ready);
    end
    sb.delete();
    m_bias = 0; m_scale = 1; m_shift = 0; m_leaky = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, a, d);
      if (out_valid) stale++;
    end
    tests++;
    if (stale != 0) begin
      fails++; $display("FAIL mid_reset_stale: %0d stale outputs required 0", stale);
    end
    cycle(1'b1, 32'd100, 1'b1, 1'b1, 1'b0, a, d);
    if (a) begin e.d = 8'd100; e.l = 1'b1; e.c = cyc; sb.push_back(e); end
    for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, a, d);
      if (d) begin
        e = sb.pop_front();
        got++;
        tests++;
        if (data_out !== e.d || out_last !== e.l) begin
          fails++;
          $display("FAIL mid_reset_cfg: data=%0d last=%0b required data=100 last=1", $signed(data_out), out_last);
        end
      end
    end
    tests++;
    if (got != 1) begin
      fails++; $display("FAIL mid_reset_count: got %0d words required 1", got);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_cfg_guard();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
